project1_nios2_qsys_0_nios2_ocimem: RTL and testbench

On-chip debug memory stage directly downstream of the JTAG debug-module wrapper. Consumes the system-clock-domain `jdo` word and the `take_action_ocimem_*` strobes, performs JTAG reads and writes into a 256×32 debug RAM, and returns read data on `MonDReg` for the next JTAG scan. The same RAM is exposed to the CPU through an Avalon-MM slave with fixed arbitration.

---
 rtl/project1_nios2_qsys_0_nios2_ocimem.sv | 168 ++++++++++++++++
 tb/tb_project1_nios2_qsys_0_nios2_ocimem.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project1_nios2_qsys_0_nios2_ocimem.sv
// OCI debug memory: 256x32 RAM shared by JTAG strobes and an Avalon-MM slave.
// JTAG requests always win arbitration; CPU accesses take one CACC cycle.
module project1_nios2_qsys_0_nios2_ocimem #(
  parameter int RAM_AW = 8,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  output logic [DW-1:0] MonDReg,
  input  logic [8:0]    address,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  input  logic [3:0]    byteenable,
  input  logic          debugaccess,
  output logic [DW-1:0] readdata,
  output logic          waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JACC = 2'd1,
    CACC = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [RAM_AW-1:0] mona_q, mona_d;
  logic [DW-1:0]     mond_q, mond_d;
  logic [DW-1:0]     wbuf_q, wbuf_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              jpend_q, jpend_d;
  logic              jwr_q, jwr_d;
  logic              jinc_q, jinc_d;
  logic              ovr_q, ovr_d;

  logic [DW-1:0] mem_q [0:(1<<RAM_AW)-1];

  logic sa, sb, sn, busy;
  logic b_sel, n_sel, drop, blocked;
  logic a_load, a_rd, b_ok, n_ok, new_req;
  logic cpu_req, ld_rd, st_rd, cwr;
  logic [RAM_AW-1:0] caddr;
  logic [DW-1:0]     ram_rd;
  logic              unused_jdo;

  assign sa = take_action_ocimem_a;
  assign sb = take_action_ocimem_b;
  assign sn = take_no_action_ocimem_a;

  assign busy    = jpend_q | (state_q == JACC);
  assign b_sel   = sb & ~sa;
  assign n_sel   = sn & ~sa & ~sb;
  assign drop    = (sa & (sb | sn)) | (sb & sn);
  assign a_load  = sa & (~jdo[34] | ~busy);
  assign a_rd    = sa & jdo[34] & ~busy;
  assign b_ok    = b_sel & ~busy;
  assign n_ok    = n_sel & ~busy;
  assign blocked = busy & ((sa & jdo[34]) | b_sel | n_sel);
  assign new_req = a_rd | b_ok | n_ok;

  assign cpu_req = chipselect & (read | write);
  assign caddr   = address[RAM_AW-1:0];
  assign ld_rd   = (state_d == CACC) & (state_q != CACC);
  assign st_rd   = ld_rd & read & (address == 9'h101);
  assign cwr     = (state_q == CACC) & chipselect & write
                 & ~address[8] & debugaccess;

  // A CPU read entering CACC straight from a JTAG write sees the new word.
  assign ram_rd = (state_q == JACC && jwr_q && mona_q == caddr)
                ? wbuf_q : mem_q[caddr];

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (jpend_q)                  state_d = JACC;
        else if (!new_req && cpu_req) state_d = CACC;
      end
      JACC:    state_d = cpu_req ? CACC : IDLE;
      CACC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    waitrequest = (state_q != CACC);
  end

  always_comb begin
    mona_d  = mona_q;
    mond_d  = mond_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    jpend_d = jpend_q;
    jwr_d   = jwr_q;
    jinc_d  = jinc_q;
    if (state_q == JACC) begin
      jpend_d = 1'b0;
      if (jinc_q) mona_d = mona_q + RAM_AW'(1);
      if (!jwr_q) mond_d = mem_q[mona_q];
    end
    if (a_load) mona_d = jdo[17:10];
    if (new_req) begin
      jpend_d = 1'b1;
      jwr_d   = b_ok;
      jinc_d  = ~a_rd;
    end
    if (b_ok) wbuf_d = jdo[34:3];
    ovr_d = drop | blocked | (ovr_q & ~st_rd);
    if (ld_rd) begin
      unique case (1'b1)
        ~address[8]:          rdata_d = ram_rd;
        address == 9'h100:    rdata_d = mond_d;
        address == 9'h101:    rdata_d = {{(DW-2){1'b0}}, ovr_q, jpend_d};
        default:              rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mona_q  <= '0;
      mond_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      jpend_q <= 1'b0;
      jwr_q   <= 1'b0;
      jinc_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      mona_q  <= mona_d;
      mond_q  <= mond_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      jpend_q <= jpend_d;
      jwr_q   <= jwr_d;
      jinc_q  <= jinc_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == JACC && jwr_q) begin
      mem_q[mona_q] <= wbuf_q;
    end else if (cwr) begin
      for (int i = 0; i < DW/8; i++) begin
        if (byteenable[i]) mem_q[caddr][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign MonDReg  = mond_q;
  assign readdata = rdata_q;

endmodule

// File: tb/tb_project1_nios2_qsys_0_nios2_ocimem.sv
// Bench for the OCI debug memory: reference model plus scoreboard queues
// for CPU read data and JTAG MonDReg results.
module tb_project1_nios2_qsys_0_nios2_ocimem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
  logic [31:0] MonDReg, readdata;
  logic        waitrequest;
  logic [8:0]  address = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;

  always #5 clk = ~clk;

  project1_nios2_qsys_0_nios2_ocimem dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .MonDReg                 (MonDReg),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest)
  );

  typedef struct { bit chk; logic [31:0] exp; int tag; } cexp_t;
  typedef struct { int due; bit chk; logic [31:0] exp; } jexp_t;

  cexp_t cq[$];
  jexp_t jq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_mem [256];
  bit          m_known [256];
  logic [7:0]  m_mona = '0;
  logic [31:0] m_mond = '0;
  bit          m_mond_k = 1'b1;
  bit          m_ovr = 1'b0;
  int          m_last = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (tag %0d): got %h expected %h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && !waitrequest) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_unexpected: waitrequest low with no request");
      end else begin
        cexp_t e;
        e = cq.pop_front();
        if (e.chk) chk("cpu_readdata", e.tag, readdata, e.exp);
      end
    end
    if (jq.size() > 0 && jq[0].due == cyc) begin
      jexp_t j;
      j = jq.pop_front();
      if (j.chk) chk("jtag_mondreg", j.due, MonDReg, j.exp);
    end
  end

  function automatic logic [37:0] mk_a(input logic [7:0] ad, input bit rd);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[17:10] = ad;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[34:3] = d;
    return j;
  endfunction

  task automatic jtag_read_expect(input int s);
    jq.push_back('{due: s + 2, chk: m_known[m_mona], exp: m_mem[m_mona]});
    m_mond   = m_mem[m_mona];
    m_mond_k = m_known[m_mona];
  endtask

  // Effect of one strobe cycle sampled at edge s, as seen from the JTAG side.
  task automatic model_strobe(input bit a, input bit b, input bit n,
                              input logic [37:0] j, input int s);
    bit busy;
    busy = (s - m_last) <= 2;
    if ((a && (b || n)) || (b && n)) m_ovr = 1'b1;
    if (a) begin
      if (!j[34]) m_mona = j[17:10];
      else if (busy) m_ovr = 1'b1;
      else begin
        m_mona = j[17:10];
        jtag_read_expect(s);
        m_last = s;
      end
    end else if (b) begin
      if (busy) m_ovr = 1'b1;
      else begin
        m_mem[m_mona]   = j[34:3];
        m_known[m_mona] = 1'b1;
        m_mona = m_mona + 8'd1;
        m_last = s;
      end
    end else if (n) begin
      if (busy) m_ovr = 1'b1;
      else begin
        jtag_read_expect(s);
        m_mona = m_mona + 8'd1;
        m_last = s;
      end
    end
  endtask

  task automatic strobe_cycle(input bit a, input bit b, input bit n,
                              input logic [37:0] j);
    jdo  = j;
    ta_a = a;
    ta_b = b;
    tn_a = n;
    @(posedge clk);
    #1;
    model_strobe(a, b, n, j, cyc);
  endtask

  task automatic idle(input int k);
    ta_a = 1'b0;
    ta_b = 1'b0;
    tn_a = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_drive(input logic [8:0] ad, input bit wr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input bit dbg);
    address     = ad;
    chipselect  = 1'b1;
    read        = !wr;
    write       = wr;
    writedata   = wd;
    byteenable  = be;
    debugaccess = dbg;
  endtask

  task automatic cpu_expect(input logic [8:0] ad, input bit wr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input bit dbg, input int tag);
    int w;
    w = int'(ad[7:0]);
    if (wr) begin
      if (!ad[8] && dbg) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_mem[w][8*i +: 8] = wd[8*i +: 8];
        if (be == 4'hF) m_known[w] = 1'b1;
      end
      cq.push_back('{chk: 1'b0, exp: 32'h0, tag: tag});
    end else if (!ad[8]) begin
      cq.push_back('{chk: m_known[w], exp: m_mem[w], tag: tag});
    end else if (ad == 9'h100) begin
      cq.push_back('{chk: m_mond_k, exp: m_mond, tag: tag});
    end else if (ad == 9'h101) begin
      cq.push_back('{chk: 1'b1, exp: {30'b0, m_ovr, 1'b0}, tag: tag});
      m_ovr = 1'b0;
    end else begin
      cq.push_back('{chk: 1'b1, exp: 32'h0, tag: tag});
    end
  endtask

  task automatic cpu_finish(input int exp_lat, input int tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (!waitrequest) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout (tag %0d): waitrequest stuck high", tag);
    end else if (exp_lat > 0) begin
      chk("cpu_latency", tag, 32'(n), 32'(exp_lat));
    end
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    if (got) chk("wait_one_cycle", tag, {31'b0, waitrequest}, 32'h1);
  endtask

  task automatic cpu_acc(input logic [8:0] ad, input bit wr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input bit dbg, input int tag);
    cpu_drive(ad, wr, wd, be, dbg);
    cpu_expect(ad, wr, wd, be, dbg, tag);
    cpu_finish(1, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ad;
    int op;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mondreg", 0, MonDReg, 32'h0);
    chk("rst_readdata", 0, readdata, 32'h0);
    chk("rst_waitreq", 0, {31'b0, waitrequest}, 32'h1);
    reset_n = 1'b1;
    idle(2);

    // Fill a 16-word window F8..07 so random reads hit known data.
    strobe_cycle(1, 0, 0, mk_a(8'hF8, 0));
    idle(2);
    for (int i = 0; i < 16; i++) begin
      strobe_cycle(0, 1, 0, mk_b($urandom()));
      idle(3);
    end

    strobe_cycle(1, 0, 0, mk_a(8'hFE, 0));  idle(3);
    strobe_cycle(0, 1, 0, mk_b(32'hDEADBEEF)); idle(3);
    strobe_cycle(0, 1, 0, mk_b(32'h12345678)); idle(3);
    strobe_cycle(1, 0, 0, mk_a(8'hFE, 1));  idle(3);
    strobe_cycle(0, 0, 1, mk_b(32'h0));     idle(3);
    strobe_cycle(0, 0, 1, mk_b(32'h0));     idle(3);

    cpu_acc(9'h0FE, 0, 32'h0, 4'h0, 0, 1);
    cpu_acc(9'h0FE, 1, 32'hAAAA5555, 4'b0011, 1, 2);
    cpu_acc(9'h0FE, 0, 32'h0, 4'h0, 0, 3);
    cpu_acc(9'h0FE, 1, 32'h11111111, 4'hF, 0, 4);
    cpu_acc(9'h0FE, 0, 32'h0, 4'h0, 0, 5);
    cpu_acc(9'h100, 0, 32'h0, 4'h0, 0, 6);

    // JTAG write and CPU read of the same (wrapped) address in one cycle.
    cpu_drive(9'h000, 0, 32'h0, 4'h0, 0);
    strobe_cycle(0, 1, 0, mk_b(32'hCAFEF00D));
    cpu_expect(9'h000, 0, 32'h0, 4'h0, 0, 7);
    ta_b = 1'b0;
    cpu_finish(2, 7);
    idle(2);

    strobe_cycle(0, 1, 1, mk_b(32'h0BADF00D)); idle(3);
    cpu_acc(9'h101, 0, 32'h0, 4'h0, 0, 8);
    cpu_acc(9'h101, 0, 32'h0, 4'h0, 0, 9);
    cpu_acc(9'h001, 0, 32'h0, 4'h0, 0, 10);

    ad = m_mona;
    strobe_cycle(0, 1, 0, mk_b(32'h01020304));
    strobe_cycle(0, 1, 0, mk_b(32'h05060708));
    idle(3);
    cpu_acc(9'h101, 0, 32'h0, 4'h0, 0, 11);
    cpu_acc(9'h101, 0, 32'h0, 4'h0, 0, 12);
    cpu_acc({1'b0, ad}, 0, 32'h0, 4'h0, 0, 13);
    cpu_acc({1'b0, ad + 8'd1}, 0, 32'h0, 4'h0, 0, 14);

    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 6));
      ad = 8'hF8 + 8'($urandom_range(0, 15));
      case (op)
        0: begin strobe_cycle(1, 0, 0, mk_a(ad, 0)); idle(3); end
        1: begin strobe_cycle(1, 0, 0, mk_a(ad, 1)); idle(3); end
        2: begin strobe_cycle(0, 1, 0, mk_b($urandom())); idle(3); end
        3: begin strobe_cycle(0, 0, 1, mk_b($urandom())); idle(3); end
        4: cpu_acc({1'b0, ad}, 0, 32'h0, 4'h0, 0, 100 + k);
        5: cpu_acc({1'b0, ad}, 1, $urandom(), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 100 + k);
        default: cpu_acc(9'h100 + 9'($urandom_range(0, 2)), 0, 32'h0,
                         4'h0, 0, 100 + k);
      endcase
    end

    // Reset asserted while a CPU read sits in CACC.
    cpu_drive(9'h0FA, 0, 32'h0, 4'h0, 0);
    cpu_expect(9'h0FA, 0, 32'h0, 4'h0, 0, 20);
    @(posedge clk);
    #1;
    chk("cacc_before_rst", 20, {31'b0, waitrequest}, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_waitreq", 20, {31'b0, waitrequest}, 32'h1);
    chk("midrst_mondreg", 20, MonDReg, 32'h0);
    chk("midrst_readdata", 20, readdata, 32'h0);
    chipselect = 1'b0;
    read = 1'b0;
    m_mona = '0;
    m_mond = '0;
    m_mond_k = 1'b1;
    m_ovr = 1'b0;
    m_last = -100;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    cpu_acc(9'h101, 0, 32'h0, 4'h0, 0, 21);
    cpu_acc(9'h100, 0, 32'h0, 4'h0, 0, 22);
    strobe_cycle(1, 0, 0, mk_a(8'hFE, 1)); idle(3);
    strobe_cycle(0, 0, 1, mk_b(32'h0));    idle(3);
    idle(4);

    if (cq.size() != 0 || jq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queues_drained: cpu %0d jtag %0d left, expected 0 0",
               cq.size(), jq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
